// File: rtl/dec3x8_pipe_pkg.sv
// Shared types and helpers for the code/one-hot encoder and decoder blocks.
// Holds the default code width, the skid occupancy state type and the decode function.
package dec3x8_pipe_pkg;

   localparam int unsigned DEF_W = 3;
   localparam int unsigned MAX_W = 8;
   localparam int unsigned MAX_N = 2 ** MAX_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   // Wide enough for any block up to MAX_W; callers keep the low 2**W bits.
   function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_W-1:0] code,
                                                 input logic             any);
      logic [MAX_N-1:0] w_word;
      w_word = '0;
      if (any) begin
         w_word[code] = 1'b1;
      end
      return w_word;
   endfunction

endpackage

// File: rtl/dec3x8_pipe_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with registered ready and output paths.
// The output register always holds the oldest word; the skid register holds the second.
module dec3x8_pipe_skid_buf2
   import dec3x8_pipe_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   occ_e          r_state;
   occ_e          w_state_d;
   logic [DW-1:0] r_out_data;
   logic [DW-1:0] w_out_data_d;
   logic [DW-1:0] r_skid_data;
   logic [DW-1:0] w_skid_data_d;
   logic          r_out_valid;
   logic          r_in_ready;
   logic          w_push;
   logic          w_pop;

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = r_out_valid & out_ready;

   always_comb begin
      w_state_d     = r_state;
      w_out_data_d  = r_out_data;
      w_skid_data_d = r_skid_data;
      unique case (r_state)
         EMPTY: begin
            if (w_push) begin
               w_out_data_d = in_data;
               w_state_d    = ONE;
            end
         end
         ONE: begin
            if (w_push && w_pop) begin
               w_out_data_d = in_data;
            end else if (w_pop) begin
               w_state_d = EMPTY;
            end else if (w_push) begin
               w_skid_data_d = in_data;
               w_state_d     = TWO;
            end
         end
         TWO: begin
            if (w_pop) begin
               w_out_data_d = r_skid_data;
               w_state_d    = ONE;
            end
         end
         default: begin
            w_state_d = EMPTY;
         end
      endcase
   end

   // Ready and valid are flopped from the next state so neither port sees a comb path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_out_data  <= '0;
         r_skid_data <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_out_data  <= w_out_data_d;
         r_skid_data <= w_skid_data_d;
         r_out_valid <= (w_state_d != EMPTY);
         r_in_ready  <= (w_state_d != TWO);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: rtl/dec3x8_pipe.sv
// Registered, flow-controlled binary-to-one-hot decoder with a saturating handshake counter.
// Decode happens ahead of the skid so buffered entries are already one-hot words.
module dec3x8_pipe
   import dec3x8_pipe_pkg::*;
#(
   parameter  int unsigned W     = DEF_W,
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned N     = 2 ** W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_code,
   input  logic             in_any,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_onehot,
   output logic [CNT_W-1:0] out_cnt
);

   logic [MAX_W-1:0] w_code_ext;
   logic [MAX_N-1:0] w_dec_full;
   logic [N-1:0]     w_dec;
   logic             w_out_valid;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;

   assign w_code_ext = MAX_W'(in_code);
   assign w_dec_full = onehot_of(w_code_ext, in_any);
   assign w_dec      = w_dec_full[N-1:0];

   if (N < MAX_N) begin : g_unused_dec
      logic w_unused_dec;
      assign w_unused_dec = ^w_dec_full[MAX_N-1:N];
   end

   dec3x8_pipe_skid_buf2 #(
      .DW (N)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_dec),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .out_data  (out_onehot)
   );

   always_comb begin
      w_cnt_d = r_cnt;
      if (w_out_valid && out_ready && (r_cnt != {CNT_W{1'b1}})) begin
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   assign out_valid = w_out_valid;
   assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_dec3x8_pipe.sv
// Directed and random-stall bench for dec3x8_pipe.
module tb_dec3x8_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_code;
   logic        in_any;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_onehot;
   logic [15:0] out_cnt;

   int errors;
   int checks;
   int exp_cnt;

   dec3x8_pipe u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_any     (in_any),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_cnt    (out_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'bx;
      out_ready = 1'bx;
      in_code   = 3'bxxx;
      in_any    = 1'bx;
      repeat (3) step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_onehot !== 8'h00 || out_cnt !== 16'd0)
      begin
         errors++;
         $display("FAIL reset_hold: rdy=%b vld=%b oh=%h cnt=%0d required 0 0 00 0",
                  in_ready, out_valid, out_onehot, out_cnt);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_code   = 3'd0;
      in_any    = 1'b0;
      rst_n     = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b vld=%b cnt=%0d required 1 0 0",
                  in_ready, out_valid, out_cnt);
      end
      exp_cnt = 0;
   endtask

   task automatic test_basic;
      in_valid  = 1'b1;
      in_code   = 3'd5;
      in_any    = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h20) begin
         errors++;
         $display("FAIL basic_word: vld=%b oh=%h required 1 20", out_valid, out_onehot);
      end
      step();
      exp_cnt++;
      checks++;
      if (out_cnt !== 16'(exp_cnt) || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_cnt: cnt=%0d vld=%b required %0d 0", out_cnt, out_valid, exp_cnt);
      end
   endtask

   task automatic test_sweep;
      logic [7:0] exp_oh;
      out_ready = 1'b1;
      in_any    = 1'b1;
      exp_oh    = 8'h01;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_code  = 3'(i);
         step();
         checks++;
         if (out_valid !== 1'b1 || out_onehot !== exp_oh || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_%0d: vld=%b oh=%h rdy=%b required 1 %h 1",
                     i, out_valid, out_onehot, in_ready, exp_oh);
         end
         exp_oh = exp_oh << 1;
      end
      in_valid = 1'b0;
      step();
      exp_cnt += 8;
      checks++;
      if (out_cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL sweep_cnt: cnt=%0d required %0d", out_cnt, exp_cnt);
      end
   endtask

   task automatic test_none;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_code   = 3'd3;
      in_any    = 1'b0;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h00) begin
         errors++;
         $display("FAIL none_word: vld=%b oh=%h required 1 00", out_valid, out_onehot);
      end
      step();
      exp_cnt++;
      checks++;
      if (out_cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL none_cnt: cnt=%0d required %0d", out_cnt, exp_cnt);
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_any    = 1'b1;
      in_valid  = 1'b1;
      in_code   = 3'd1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h02 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: vld=%b oh=%h rdy=%b required 1 02 1",
                  out_valid, out_onehot, in_ready);
      end
      in_code = 3'd6;
      step();
      checks++;
      if (in_ready !== 1'b0 || out_onehot !== 8'h02) begin
         errors++;
         $display("FAIL bp_full: rdy=%b oh=%h required 0 02", in_ready, out_onehot);
      end
      // Offered while full: must be ignored.
      in_code = 3'd3;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 8'h02) begin
            errors++;
            $display("FAIL bp_hold_%0d: rdy=%b vld=%b oh=%h required 0 1 02",
                     i, in_ready, out_valid, out_onehot);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h40 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: vld=%b oh=%h rdy=%b required 1 40 1",
                  out_valid, out_onehot, in_ready);
      end
      step();
      exp_cnt += 2;
      checks++;
      if (out_valid !== 1'b0 || out_cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL bp_drain: vld=%b cnt=%0d required 0 %0d", out_valid, out_cnt, exp_cnt);
      end
   endtask

   task automatic test_random;
      logic [7:0] q[$];
      logic [7:0] exp_oh;
      logic [7:0] held;
      logic       hold_chk;
      int         sent;
      int         rcvd;
      int         cyc;
      sent     = 0;
      rcvd     = 0;
      cyc      = 0;
      hold_chk = 1'b0;
      held     = 8'h00;
      while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
         in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_code   = 3'($urandom_range(0, 7));
         in_any    = ($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 1));
         if (hold_chk) begin
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== held) begin
               errors++;
               $display("FAIL rand_stable: vld=%b oh=%h required 1 %h", out_valid, out_onehot, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra: oh=%h required no word", out_onehot);
            end else begin
               exp_oh = q.pop_front();
               if (out_onehot !== exp_oh) begin
                  errors++;
                  $display("FAIL rand_word_%0d: oh=%h required %h", rcvd, out_onehot, exp_oh);
               end
            end
            rcvd++;
            exp_cnt++;
         end
         if (in_valid && in_ready) begin
            exp_oh = 8'h00;
            if (in_any) exp_oh[in_code] = 1'b1;
            q.push_back(exp_oh);
            sent++;
         end
         hold_chk = out_valid && !out_ready;
         held     = out_onehot;
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (cyc >= 20000 || rcvd != 1000) begin
         errors++;
         $display("FAIL rand_timeout: sent=%0d rcvd=%0d required 1000 1000", sent, rcvd);
      end
      checks++;
      if (out_cnt !== 16'(exp_cnt) || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_cnt: cnt=%0d vld=%b required %0d 0", out_cnt, out_valid, exp_cnt);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      in_any    = 1'b1;
      in_valid  = 1'b1;
      in_code   = 3'd2;
      step();
      in_code = 3'd7;
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_onehot !== 8'h04) begin
         errors++;
         $display("FAIL mid_fill: rdy=%b oh=%h required 0 04", in_ready, out_onehot);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_onehot !== 8'h00 || out_cnt !== 16'd0 || in_ready !== 1'b0)
      begin
         errors++;
         $display("FAIL mid_async: vld=%b oh=%h cnt=%0d rdy=%b required 0 00 0 0",
                  out_valid, out_onehot, out_cnt, in_ready);
      end
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      exp_cnt   = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || out_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_stale_%0d: vld=%b cnt=%0d required 0 0", i, out_valid, out_cnt);
         end
      end
      in_valid = 1'b1;
      in_code  = 3'd4;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h10) begin
         errors++;
         $display("FAIL mid_resume: vld=%b oh=%h required 1 10", out_valid, out_onehot);
      end
      step();
      checks++;
      if (out_cnt !== 16'd1) begin
         errors++;
         $display("FAIL mid_cnt: cnt=%0d required 1", out_cnt);
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      exp_cnt = 0;
      test_reset();
      test_basic();
      test_sweep();
      test_none();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
